adc_scan_scheduler: RTL
=======================

ADC_SCAN_SCHEDULER -- requirements
Module: adc_scan_scheduler

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 12000, is the RX byte watchdog in clk12MHz cycles (1 ms).
REQ-002 Parameter ADC_ID_BASE, default 8'hA1, is the command byte for channel 0; channel n sends ADC_ID_BASE+n.
REQ-003 Port clk12MHz, input, 1: the single clock; all logic on its rising edge.
REQ-004 Port reset, input, 1: synchronous, active-high reset.
REQ-005 Port chan_mask, input, 4: channel enable, bit n = channel n (X1..X4).
REQ-006 Port continuous, input, 1: 1 = scan forever; 0 = one sweep per start.
REQ-007 Port start, input, 1: one-cycle pulse launching a sweep when continuous=0.
REQ-008 Port tx_req / tx_data, output, 1 / 8: level request and byte to the UART sender.
REQ-009 Port tx_done, input, 1: sender done, held until tx_req falls.
REQ-010 Port rx_arm, output, 1: receiver enable, level.
REQ-011 Port rx_valid / rx_data, input, 1 / 8: byte ready, held until rx_arm falls.
REQ-012 Port rd_chan / rd_en, input, 2 / 1: result read select and read strobe.
REQ-013 Port rd_data, output, 10: stored result of rd_chan, combinational mux.
REQ-014 Port fresh, output, 4: per-channel new-result flags.
REQ-015 Port err / err_clr, output 4 / input 1: sticky per-channel timeout flags and their clear.
REQ-016 Port busy, output, 1: high whenever the FSM is outside IDLE.

Function
REQ-017 FSM states: IDLE, PICK, SEND, RX_LO, GAP, RX_HI, STORE.
REQ-018 IDLE->PICK when chan_mask!=0 and either continuous=1 or start=1. Otherwise IDLE holds, including when start arrives with chan_mask=0.
REQ-019 PICK selects the lowest enabled channel above the last-served channel, wrapping 3->0. After reset the last-served channel is 3, so the first pick is the lowest enabled channel. PICK samples chan_mask in that cycle only.
REQ-020 PICK->IDLE without a transaction if chan_mask=0.
REQ-021 SEND: tx_data = ADC_ID_BASE+ch and tx_req=1 until tx_done=1. The same edge drops tx_req, raises rx_arm and enters RX_LO.
REQ-022 RX_LO: on rx_valid=1, capture rx_data as low byte, drop rx_arm, enter GAP.
REQ-023 GAP: wait for rx_valid=0, then raise rx_arm and enter RX_HI. RX_HI captures rx_data[1:0] as bits 9:8 and drops rx_arm.
REQ-024 STORE: write the 10-bit result to the channel's register and set fresh[ch]. If continuous=0 and ch is the highest enabled channel, go to IDLE; otherwise go to PICK.
REQ-025 Watchdog: counter clears on every entry to RX_LO or RX_HI. Reaching TIMEOUT_CYCLES-1 sets err[ch], drops rx_arm and goes to PICK (continuous) or IDLE (sweep end). The result is not written.
REQ-026 rd_en=1 clears fresh[rd_chan]. A STORE set on the same channel in the same cycle wins, so fresh stays 1.
REQ-027 err_clr=1 clears all err bits. A timeout set in the same cycle wins.
REQ-028 start pulses while busy=1 are ignored. A chan_mask change takes effect at the next PICK.
REQ-029 Command-to-store latency equals the UART time; the block adds at most 1 cycle per state transition.

Reset
REQ-030 reset=1 forces, on the next edge: state IDLE, tx_req=0, rx_arm=0, tx_data=0, busy=0, fresh=0, err=0, all results 0, last-served=3, watchdog=0.
REQ-031 Reset in any state, including mid-RX, abandons the transaction; partial bytes are discarded.

Configuration
REQ-032 Macro ADC_SCAN_AVG_EN defined: STORE writes (old+new)>>1 using an 11-bit sum. The first store after reset writes new directly, tracked by a per-channel seen bit.
REQ-033 Macro ADC_SCAN_AVG_EN undefined: STORE writes new directly; no seen bits or adder.

Structure
REQ-034 Package adc_scan_pkg holds the state encoding, NUM_CH=4, RESULT_W=10 and the ADC_ID_BASE default.
REQ-035 Sub-module adc_rr_pick is combinational: inputs mask[3:0] and last[1:0]; outputs next[1:0], any and is_last (next is the highest enabled channel).

Verification
REQ-036 Single sweep: mask=0001, start, rx 0x34 then 0x02 -> tx_data=A1, rd_data(ch0)=0x234, fresh=0001, busy falls.
REQ-037 Round-robin: continuous=1, mask=1010 -> command sequence A2, A4, A2, A4. Mask changed to 0100 mid-RX -> next command A3.
REQ-038 Timeout: mask=0001, no rx_valid after tx_done -> after TIMEOUT_CYCLES err=0001, rx_arm=0, result unchanged. err_clr -> err=0000.
REQ-039 Reset asserted in RX_HI -> next edge tx_req=0, rx_arm=0, busy=0, all results 0. Next start -> first command A1 with mask=1111.
REQ-040 Collision: rd_en on ch0 coincident with STORE to ch0 -> fresh[0]=1. rd_en on a later cycle -> fresh[0]=0.
REQ-041 ADC_SCAN_AVG_EN: ch0 samples 0x100 then 0x200 -> stored 0x100, then 0x180.

Source files
------------

// File: rtl/adc_scan_scheduler_pkg.sv
// Shared types and constants for the ADC scan scheduler: FSM state encoding,
// channel count, result width and the default channel-0 command byte.
package adc_scan_pkg;

    localparam int NUM_CH = 4;
    localparam int RESULT_W = 10;
    localparam logic [7:0] ADC_ID_BASE_DEF = 8'hA1;

    typedef enum logic [2:0] {
        IDLE,
        PICK,
        SEND,
        RX_LO,
        GAP,
        RX_HI,
        STORE
    } state_t;

endpackage

// File: rtl/adc_scan_scheduler_if.sv
// UART-side handshake bundle: command byte out to the sender, result bytes in
// from the receiver. master = scheduler, slave = UART.
interface adc_scan_scheduler_if;
    logic       tx_req;
    logic [7:0] tx_data;
    logic       tx_done;
    logic       rx_arm;
    logic       rx_valid;
    logic [7:0] rx_data;

    modport master (
        output tx_req, tx_data, rx_arm,
        input  tx_done, rx_valid, rx_data
    );

    modport slave (
        input  tx_req, tx_data, rx_arm,
        output tx_done, rx_valid, rx_data
    );
endinterface

// File: rtl/adc_scan_scheduler_rr_pick.sv
// Round-robin channel picker: lowest enabled channel above last, wrapping,
// plus a flag telling whether that channel is the highest enabled one.
module adc_rr_pick (
    input  logic [3:0] mask,
    input  logic [1:0] last,
    output logic [1:0] next,
    output logic       any,
    output logic       is_last
);
    logic [1:0] cand;
    logic [1:0] highest;

    always_comb begin
        next    = '0;
        any     = 1'b0;
        cand    = '0;
        highest = '0;
        // i = 4 wraps back onto last itself, so a single-channel mask still picks
        for (int i = 1; i <= 4; i++) begin
            cand = last + 2'(i);
            if (!any && mask[cand]) begin
                next = cand;
                any  = 1'b1;
            end
        end
        for (int i = 0; i < 4; i++) begin
            if (mask[i]) highest = 2'(i);
        end
        is_last = any && (next == highest);
    end
endmodule

// File: rtl/adc_scan_scheduler.sv
// ADC scan scheduler: round-robin command/response sequencing over a UART link
// with per-channel result registers. Define ADC_SCAN_AVG_EN to average stores.
module adc_scan_scheduler
    import adc_scan_pkg::*;
#(
    parameter int         TIMEOUT_CYCLES = 12000,
    parameter logic [7:0] ADC_ID_BASE    = ADC_ID_BASE_DEF
) (
    input  logic                 clk12MHz,
    input  logic                 reset,
    adc_scan_scheduler_if.master bus,
    input  logic [NUM_CH-1:0]    chan_mask,
    input  logic                 continuous,
    input  logic                 start,
    input  logic [1:0]           rd_chan,
    input  logic                 rd_en,
    output logic [RESULT_W-1:0]  rd_data,
    output logic [NUM_CH-1:0]    fresh,
    output logic [NUM_CH-1:0]    err,
    input  logic                 err_clr,
    output logic                 busy
);
    // state | meaning
    // IDLE  | waiting for start or continuous mode
    // PICK  | choose next enabled channel round-robin
    // SEND  | command byte offered to the UART sender
    // RX_LO | receiver armed for result low byte
    // GAP   | waiting for rx_valid to drop between bytes
    // RX_HI | receiver armed for result bits 9:8
    // STORE | write result, set fresh flag

    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

    state_t state, state_next;
    logic [1:0] ch, last_served;
    logic last_q;
    logic [7:0] lo_byte;
    logic [1:0] hi_bits;
    logic [WD_W-1:0] wd;
    logic tx_req_q, rx_arm_q, tx_req_next, rx_arm_next;
    logic [7:0] tx_data_q;
    logic [RESULT_W-1:0] result [NUM_CH];
    logic [RESULT_W-1:0] new_val, store_val;
    logic [NUM_CH-1:0] fresh_next, err_next;
    logic pick_any, pick_is_last;
    logic [1:0] pick_next;
    logic do_pick, wd_clr, cap_lo, cap_hi, do_store, do_timeout;
    logic wd_hit, sweep_done;

    adc_rr_pick u_pick (
        .mask    (chan_mask),
        .last    (last_served),
        .next    (pick_next),
        .any     (pick_any),
        .is_last (pick_is_last)
    );

    assign wd_hit     = (wd == WD_W'(TIMEOUT_CYCLES - 1));
    assign sweep_done = !continuous && last_q;
    assign new_val    = {hi_bits, lo_byte};

`ifdef ADC_SCAN_AVG_EN
    logic [NUM_CH-1:0] seen;
    logic [RESULT_W:0] sum;
    assign sum       = {1'b0, result[ch]} + {1'b0, new_val};
    assign store_val = seen[ch] ? RESULT_W'(sum >> 1) : new_val;
`else
    assign store_val = new_val;
`endif

    always_comb begin
        state_next  = state;
        tx_req_next = tx_req_q;
        rx_arm_next = rx_arm_q;
        do_pick     = 1'b0;
        wd_clr      = 1'b0;
        cap_lo      = 1'b0;
        cap_hi      = 1'b0;
        do_store    = 1'b0;
        do_timeout  = 1'b0;
        case (state)
            IDLE: if (chan_mask != '0 && (continuous || start)) state_next = PICK;
            PICK: begin
                if (pick_any) begin
                    do_pick     = 1'b1;
                    tx_req_next = 1'b1;
                    state_next  = SEND;
                end else begin
                    state_next = IDLE;
                end
            end
            SEND: if (bus.tx_done) begin
                tx_req_next = 1'b0;
                rx_arm_next = 1'b1;
                wd_clr      = 1'b1;
                state_next  = RX_LO;
            end
            RX_LO, RX_HI: begin
                if (bus.rx_valid) begin
                    cap_lo      = (state == RX_LO);
                    cap_hi      = (state == RX_HI);
                    rx_arm_next = 1'b0;
                    state_next  = (state == RX_LO) ? GAP : STORE;
                end else if (wd_hit) begin
                    do_timeout  = 1'b1;
                    rx_arm_next = 1'b0;
                    state_next  = sweep_done ? IDLE : PICK;
                end
            end
            GAP: if (!bus.rx_valid) begin
                rx_arm_next = 1'b1;
                wd_clr      = 1'b1;
                state_next  = RX_HI;
            end
            STORE: begin
                do_store   = 1'b1;
                state_next = sweep_done ? IDLE : PICK;
            end
            default: state_next = IDLE;
        endcase
    end

    // set beats clear on both flag vectors
    always_comb begin
        fresh_next = fresh;
        err_next   = err;
        if (rd_en) fresh_next[rd_chan] = 1'b0;
        if (do_store) fresh_next[ch] = 1'b1;
        if (err_clr) err_next = '0;
        if (do_timeout) err_next[ch] = 1'b1;
    end

    always_ff @(posedge clk12MHz) begin
        if (reset) begin
            state       <= IDLE;
            tx_req_q    <= 1'b0;
            rx_arm_q    <= 1'b0;
            tx_data_q   <= '0;
            ch          <= '0;
            last_served <= 2'd3;
            last_q      <= 1'b0;
            lo_byte     <= '0;
            hi_bits     <= '0;
            wd          <= '0;
            fresh       <= '0;
            err         <= '0;
            for (int i = 0; i < NUM_CH; i++) result[i] <= '0;
`ifdef ADC_SCAN_AVG_EN
            seen        <= '0;
`endif
        end else begin
            state    <= state_next;
            tx_req_q <= tx_req_next;
            rx_arm_q <= rx_arm_next;
            fresh    <= fresh_next;
            err      <= err_next;
            if (do_pick) begin
                ch          <= pick_next;
                last_served <= pick_next;
                last_q      <= pick_is_last;
                tx_data_q   <= ADC_ID_BASE + 8'(pick_next);
            end
            if (wd_clr) wd <= '0;
            else if (state == RX_LO || state == RX_HI) wd <= wd + WD_W'(1);
            if (cap_lo) lo_byte <= bus.rx_data;
            if (cap_hi) hi_bits <= bus.rx_data[1:0];
            if (do_store) begin
                result[ch] <= store_val;
`ifdef ADC_SCAN_AVG_EN
                seen[ch]   <= 1'b1;
`endif
            end
        end
    end

    assign bus.tx_req  = tx_req_q;
    assign bus.tx_data = tx_data_q;
    assign bus.rx_arm  = rx_arm_q;
    assign rd_data     = result[rd_chan];
    assign busy        = (state != IDLE);
endmodule
